// File: rtl/cpu_scoreboard_pkg.sv
// Shared types and constants for the long-latency issue scoreboard:
// op class encodings, divider ownership states and register one-hot helper.
package cpu_scoreboard_pkg;

  localparam int unsigned MAX_PENDING_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned NREGS           = 32;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'b00,
    CLS_LOAD   = 2'b01,
    CLS_DIV    = 2'b10,
    CLS_RSVD   = 2'b11
  } op_class_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // Register number to one-hot mask; callers exclude r0 themselves.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    return NREGS'(1) << r;
  endfunction

endpackage

// File: rtl/cpu_scoreboard_if.sv
// Decoder/writeback-side bundle of the scoreboard: p2 issue request,
// late writeback port and the stall/status signals returned to the pipe.
interface cpu_scoreboard_if #(
  parameter int unsigned CNT_W = 4
);

  logic             stall_in;
  logic             p2_valid;
  logic             p2_a_is_reg;
  logic             p2_b_is_reg;
  logic [4:0]       p2_reg_a;
  logic [4:0]       p2_reg_b;
  logic [4:0]       p2_reg_d;
  logic [1:0]       p2_class;
  logic             p3_jump;
  logic             wb_valid;
  logic [4:0]       wb_reg_d;
  logic             wb_is_div;

  logic             sb_stall;
  logic             issue_fire;
  logic             div_start;
  logic             div_busy;
  logic [CNT_W-1:0] pending_count;
  logic [31:0]      pending_mask;
  logic             err_spurious;

  modport master (
    output stall_in, p2_valid, p2_a_is_reg, p2_b_is_reg, p2_reg_a, p2_reg_b,
           p2_reg_d, p2_class, p3_jump, wb_valid, wb_reg_d, wb_is_div,
    input  sb_stall, issue_fire, div_start, div_busy, pending_count,
           pending_mask, err_spurious
  );

  modport slave (
    input  stall_in, p2_valid, p2_a_is_reg, p2_b_is_reg, p2_reg_a, p2_reg_b,
           p2_reg_d, p2_class, p3_jump, wb_valid, wb_reg_d, wb_is_div,
    output sb_stall, issue_fire, div_start, div_busy, pending_count,
           pending_mask, err_spurious
  );

endinterface

// File: rtl/cpu_scoreboard_divfsm.sv
// Ownership FSM for the single iterative divider; a new divide may launch
// in the same cycle the previous one writes back.
module cpu_scoreboard_divfsm
  import cpu_scoreboard_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic div_start_i,
  input  logic div_done_i,
  output logic div_busy_o
);

  div_state_e state_q, state_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (div_start_i) state_d = DIV_BUSY;
      // A coincident start is a back-to-back handoff and keeps ownership.
      DIV_BUSY: if (div_done_i && !div_start_i) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign div_busy_o = (state_q == DIV_BUSY);

endmodule

// File: rtl/cpu_scoreboard.sv
// Issue-hazard scoreboard at p2: tracks registers awaiting long-latency
// results, stalls dependent issue and arbitrates the shared divider.
module cpu_scoreboard
  import cpu_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
)(
  input  logic             clock,
  input  logic             reset,
  cpu_scoreboard_if.slave  sb_io
);

  logic [NREGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [NREGS-1:0] clr_mask, eff_mask, set_mask;
  logic             is_div, is_long, live;
  logic             haz_a, haz_b, haz_d, full, div_conflict;
  logic             spurious, wb_ok;
  logic             sb_stall, issue_fire, div_start, div_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    is_div  = (sb_io.p2_class == CLS_DIV);
    is_long = (sb_io.p2_class == CLS_LOAD) || is_div;
    live    = sb_io.p2_valid && !sb_io.p3_jump;

    // A writeback with nothing to retire is flagged and otherwise ignored.
    spurious = sb_io.wb_valid &&
               ((count_q == '0) ||
                (sb_io.wb_reg_d != '0 && !mask_q[sb_io.wb_reg_d]) ||
                (sb_io.wb_is_div && !div_busy));
    wb_ok    = sb_io.wb_valid && !spurious;

    clr_mask = (sb_io.wb_valid && sb_io.wb_reg_d != '0) ?
               reg_onehot(sb_io.wb_reg_d) : '0;
    // Same-cycle writebacks are forwarded, so they never stall a consumer.
    eff_mask = mask_q & ~clr_mask;

    haz_a = sb_io.p2_a_is_reg && sb_io.p2_reg_a != '0 && eff_mask[sb_io.p2_reg_a];
    haz_b = sb_io.p2_b_is_reg && sb_io.p2_reg_b != '0 && eff_mask[sb_io.p2_reg_b];
    haz_d = sb_io.p2_reg_d != '0 && eff_mask[sb_io.p2_reg_d];

    full         = is_long && ((count_q - CNT_W'(wb_ok)) == CNT_W'(MAX_PENDING));
    div_conflict = is_div && div_busy && !(sb_io.wb_valid && sb_io.wb_is_div);

    sb_stall   = live && (haz_a || haz_b || haz_d || full || div_conflict);
    issue_fire = live && !sb_io.stall_in && !sb_stall;
    div_start  = issue_fire && is_div;

    set_mask = (issue_fire && is_long && sb_io.p2_reg_d != '0) ?
               reg_onehot(sb_io.p2_reg_d) : '0;
    mask_d   = (wb_ok ? eff_mask : mask_q) | set_mask;
    count_d  = count_q + CNT_W'(issue_fire && is_long) - CNT_W'(wb_ok);
    err_d    = err_q | spurious;
  end

  cpu_scoreboard_divfsm u_divfsm (
    .clock       (clock),
    .reset       (reset),
    .div_start_i (div_start),
    .div_done_i  (sb_io.wb_valid && sb_io.wb_is_div),
    .div_busy_o  (div_busy)
  );

  assign sb_io.sb_stall      = sb_stall;
  assign sb_io.issue_fire    = issue_fire;
  assign sb_io.div_start     = div_start;
  assign sb_io.div_busy      = div_busy;
  assign sb_io.pending_count = count_q;
  assign sb_io.pending_mask  = mask_q;
  assign sb_io.err_spurious  = err_q;

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed bench for cpu_scoreboard: hazards, capacity, divider handoff,
// squash, spurious writeback and asynchronous reset.
module tb_cpu_scoreboard;
  import cpu_scoreboard_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  cpu_scoreboard_if #(.CNT_W(4)) bus ();

  cpu_scoreboard #(.MAX_PENDING(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .sb_io (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    bus.stall_in    = 1'b0;
    bus.p2_valid    = 1'b0;
    bus.p2_a_is_reg = 1'b0;
    bus.p2_b_is_reg = 1'b0;
    bus.p2_reg_a    = 5'd0;
    bus.p2_reg_b    = 5'd0;
    bus.p2_reg_d    = 5'd0;
    bus.p2_class    = 2'b00;
    bus.p3_jump     = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_reg_d    = 5'd0;
    bus.wb_is_div   = 1'b0;
  endtask

  task automatic set_p2(input logic [1:0] cls, input logic a_is, input logic [4:0] a,
                        input logic b_is, input logic [4:0] b, input logic [4:0] d);
    bus.p2_valid    = 1'b1;
    bus.p2_class    = cls;
    bus.p2_a_is_reg = a_is;
    bus.p2_reg_a    = a;
    bus.p2_b_is_reg = b_is;
    bus.p2_reg_b    = b;
    bus.p2_reg_d    = d;
  endtask

  task automatic set_wb(input logic [4:0] r, input logic dv);
    bus.wb_valid  = 1'b1;
    bus.wb_reg_d  = r;
    bus.wb_is_div = dv;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clr_in();
    tick();
    tick();
    n_cmp++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL rst_mask: got %h want %h", bus.pending_mask, 32'h0); end
    n_cmp++; if (bus.pending_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.pending_count); end
    n_cmp++; if (bus.div_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.div_busy); end
    n_cmp++; if (bus.err_spurious !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.err_spurious); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
    #1;
    n_cmp++; if (bus.issue_fire !== 1'b1) begin n_err++; $display("FAIL raw_load_fire: got %b want 1", bus.issue_fire); end
    tick();
    n_cmp++; if (bus.pending_mask !== 32'h0000_0020) begin n_err++; $display("FAIL raw_mask_set: got %h want %h", bus.pending_mask, 32'h20); end
    set_p2(CLS_SINGLE, 1'b1, 5'd5, 1'b1, 5'd1, 5'd7);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b1 || bus.issue_fire !== 1'b0) begin n_err++; $display("FAIL raw_stall: got stall=%b fire=%b want 1/0", bus.sb_stall, bus.issue_fire); end
    tick();
    n_cmp++; if (bus.sb_stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_hold: got %b want 1", bus.sb_stall); end
    set_wb(5'd5, 1'b0);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b0 || bus.issue_fire !== 1'b1) begin n_err++; $display("FAIL raw_fwd_release: got stall=%b fire=%b want 0/1", bus.sb_stall, bus.issue_fire); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_mask !== 32'h0 || bus.pending_count !== 4'd0) begin n_err++; $display("FAIL raw_cleared: got mask=%h cnt=%0d want 0/0", bus.pending_mask, bus.pending_count); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'(i));
      #1;
      n_cmp++; if (bus.issue_fire !== 1'b1) begin n_err++; $display("FAIL full_fill_%0d: got fire=%b want 1", i, bus.issue_fire); end
      tick();
    end
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b1 || bus.pending_count !== 4'd4) begin n_err++; $display("FAIL full_stall: got stall=%b cnt=%0d want 1/4", bus.sb_stall, bus.pending_count); end
    set_p2(CLS_SINGLE, 1'b1, 5'd11, 1'b0, 5'd0, 5'd10);
    #1;
    n_cmp++; if (bus.issue_fire !== 1'b1) begin n_err++; $display("FAIL full_single_ok: got fire=%b want 1", bus.issue_fire); end
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6);
    tick();
    set_wb(5'd2, 1'b0);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b0 || bus.issue_fire !== 1'b1) begin n_err++; $display("FAIL full_wb_release: got stall=%b fire=%b want 0/1", bus.sb_stall, bus.issue_fire); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_count !== 4'd4 || bus.pending_mask !== 32'h0000_005A) begin n_err++; $display("FAIL full_after: got cnt=%0d mask=%h want 4/%h", bus.pending_count, bus.pending_mask, 32'h5A); end
    set_wb(5'd1, 1'b0); tick();
    set_wb(5'd3, 1'b0); tick();
    set_wb(5'd4, 1'b0); tick();
    set_wb(5'd6, 1'b0); tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_count !== 4'd0 || bus.pending_mask !== 32'h0 || bus.err_spurious !== 1'b0) begin n_err++; $display("FAIL full_drain: got cnt=%0d mask=%h err=%b want 0/0/0", bus.pending_count, bus.pending_mask, bus.err_spurious); end
  endtask

  task automatic test_div();
    set_p2(CLS_DIV, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8);
    #1;
    n_cmp++; if (bus.div_start !== 1'b1 || bus.issue_fire !== 1'b1) begin n_err++; $display("FAIL div_start1: got start=%b fire=%b want 1/1", bus.div_start, bus.issue_fire); end
    tick();
    n_cmp++; if (bus.div_busy !== 1'b1 || bus.pending_mask !== 32'h0000_0100) begin n_err++; $display("FAIL div_busy1: got busy=%b mask=%h want 1/%h", bus.div_busy, bus.pending_mask, 32'h100); end
    set_p2(CLS_DIV, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b1 || bus.div_start !== 1'b0) begin n_err++; $display("FAIL div_conflict: got stall=%b start=%b want 1/0", bus.sb_stall, bus.div_start); end
    tick();
    set_wb(5'd8, 1'b1);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b0 || bus.div_start !== 1'b1) begin n_err++; $display("FAIL div_handoff: got stall=%b start=%b want 0/1", bus.sb_stall, bus.div_start); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.div_busy !== 1'b1 || bus.pending_mask !== 32'h0000_0200 || bus.pending_count !== 4'd1) begin n_err++; $display("FAIL div_b2b: got busy=%b mask=%h cnt=%0d want 1/%h/1", bus.div_busy, bus.pending_mask, bus.pending_count, 32'h200); end
    set_wb(5'd9, 1'b1);
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.div_busy !== 1'b0 || bus.pending_mask !== 32'h0 || bus.pending_count !== 4'd0) begin n_err++; $display("FAIL div_done: got busy=%b mask=%h cnt=%0d want 0/0/0", bus.div_busy, bus.pending_mask, bus.pending_count); end
  endtask

  task automatic test_stall_in();
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    tick();
    bus.stall_in = 1'b1;
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
    set_wb(5'd3, 1'b0);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b0 || bus.issue_fire !== 1'b0) begin n_err++; $display("FAIL stallin_block: got stall=%b fire=%b want 0/0", bus.sb_stall, bus.issue_fire); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_mask !== 32'h0 || bus.pending_count !== 4'd0) begin n_err++; $display("FAIL stallin_wb: got mask=%h cnt=%0d want 0/0", bus.pending_mask, bus.pending_count); end
  endtask

  task automatic test_jump();
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    tick();
    set_p2(CLS_SINGLE, 1'b1, 5'd3, 1'b0, 5'd0, 5'd12);
    bus.p3_jump = 1'b1;
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b0 || bus.issue_fire !== 1'b0) begin n_err++; $display("FAIL jump_squash: got stall=%b fire=%b want 0/0", bus.sb_stall, bus.issue_fire); end
    tick();
    bus.p3_jump = 1'b0;
    #1;
    n_cmp++; if (bus.pending_mask !== 32'h0000_0008 || bus.sb_stall !== 1'b1) begin n_err++; $display("FAIL jump_keep: got mask=%h stall=%b want %h/1", bus.pending_mask, bus.sb_stall, 32'h8); end
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    #1;
    n_cmp++; if (bus.sb_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall: got %b want 1", bus.sb_stall); end
    clr_in();
    set_wb(5'd3, 1'b0);
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_count !== 4'd0) begin n_err++; $display("FAIL jump_drain: got cnt=%0d want 0", bus.pending_count); end
  endtask

  task automatic test_spurious();
    set_wb(5'd12, 1'b0);
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.err_spurious !== 1'b1 || bus.pending_mask !== 32'h0 || bus.pending_count !== 4'd0) begin n_err++; $display("FAIL spur_set: got err=%b mask=%h cnt=%0d want 1/0/0", bus.err_spurious, bus.pending_mask, bus.pending_count); end
    tick();
    tick();
    n_cmp++; if (bus.err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_sticky: got %b want 1", bus.err_spurious); end
  endtask

  task automatic test_async_reset();
    set_p2(CLS_DIV, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8); tick();
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1); tick();
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd2); tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_count !== 4'd3 || bus.div_busy !== 1'b1) begin n_err++; $display("FAIL areset_pre: got cnt=%0d busy=%b want 3/1", bus.pending_count, bus.div_busy); end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.pending_count !== 4'd0 || bus.pending_mask !== 32'h0 || bus.div_busy !== 1'b0 || bus.err_spurious !== 1'b0) begin n_err++; $display("FAIL areset_clear: got cnt=%0d mask=%h busy=%b err=%b want 0/0/0/0", bus.pending_count, bus.pending_mask, bus.div_busy, bus.err_spurious); end
    tick();
    reset = 1'b1;
    tick();
    set_p2(CLS_LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.pending_count !== 4'd1 || bus.pending_mask !== 32'h0000_0010) begin n_err++; $display("FAIL areset_resume: got cnt=%0d mask=%h want 1/%h", bus.pending_count, bus.pending_mask, 32'h10); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_raw();
    test_full();
    test_div();
    test_stall_in();
    test_jump();
    test_spurious();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
